// File: rtl/param_pkg.sv
// Shared interconnect parameters and the enums used by the main-memory arbiter.
package param_pkg;

    localparam int BYTES_PER_LINE   = 16;
    localparam int MAIN_MEM_LINE_AW = 26;

    typedef enum logic {ARB_FIXED, ARB_RR} arb_mode_e;

    typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_e;

endpackage

// File: rtl/mem_arb_picker.sv
// Combinational winner selection for the main-memory arbiter: round-robin search
// from a pointer, or fixed priority where promoted (starved) masters go first.
module mem_arb_picker
    import param_pkg::*;
#(
    parameter int NUM_MASTER = 4
) (
    input  logic [NUM_MASTER-1:0]         i_req,
    input  logic [$clog2(NUM_MASTER)-1:0] i_ptr,
    input  logic [NUM_MASTER-1:0]         i_promo,
    input  arb_mode_e                     i_mode,
    output logic [NUM_MASTER-1:0]         o_winner,
    output logic [$clog2(NUM_MASTER)-1:0] o_idx
);

    localparam int PW = $clog2(NUM_MASTER);

    logic [NUM_MASTER-1:0] w_pool;
    logic                  w_found;
    int                    w_j;

    always_comb begin
        o_winner = '0;
        o_idx    = '0;
        w_found  = 1'b0;
        w_j      = 0;
        w_pool   = '0;
        if (i_mode == ARB_RR) begin
            // Walk upward from the pointer, wrapping past the top master.
            for (int k = 0; k < NUM_MASTER; k++) begin
                w_j = int'(i_ptr) + k;
                if (w_j >= NUM_MASTER) begin
                    w_j = w_j - NUM_MASTER;
                end
                if (!w_found && i_req[w_j]) begin
                    o_winner[w_j] = 1'b1;
                    o_idx         = PW'(w_j);
                    w_found       = 1'b1;
                end
            end
        end else begin
            w_pool = (|(i_req & i_promo)) ? (i_req & i_promo) : i_req;
            for (int k = 0; k < NUM_MASTER; k++) begin
                if (!w_found && w_pool[k]) begin
                    o_winner[k] = 1'b1;
                    o_idx       = PW'(k);
                    w_found     = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/main_mem_arb_n.sv
// N-master arbiter in front of the single main-memory line port; a grant is held
// until memory acks, and the next winner is chosen in that same ack cycle.
module main_mem_arb_n
    import param_pkg::*;
#(
    parameter int        NUM_MASTER   = 4,
    parameter int        LINE_W       = BYTES_PER_LINE * 8,
    parameter int        AW           = MAIN_MEM_LINE_AW,
    parameter arb_mode_e ARB_MODE     = ARB_RR,
    parameter int        STARVE_LIMIT = 8
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic [NUM_MASTER-1:0]        req_i,
    input  logic [NUM_MASTER*LINE_W-1:0] wdata_i,
    input  logic [NUM_MASTER*AW-1:0]     waddr_i,
    input  logic [NUM_MASTER*AW-1:0]     raddr_i,
    input  logic [NUM_MASTER-1:0]        wcyc_i,
    input  logic [NUM_MASTER-1:0]        rcyc_i,
    input  logic                         ack_i,
    output logic [NUM_MASTER-1:0]        ack_o,
    output logic [LINE_W-1:0]            wdata_o,
    output logic [AW-1:0]                waddr_o,
    output logic [AW-1:0]                raddr_o,
    output logic                         wcyc_o,
    output logic                         rcyc_o,
    output logic [NUM_MASTER-1:0]        grant_o,
    output logic                         busy_o
);

    localparam int PW = $clog2(NUM_MASTER);
    localparam int CW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

    arb_state_e            r_state;
    logic [NUM_MASTER-1:0] r_grant;
    logic [PW-1:0]         r_ptr;
    logic [CW-1:0]         r_starve [NUM_MASTER];

    logic [NUM_MASTER-1:0] w_maskedReq;
    logic [NUM_MASTER-1:0] w_promo;
    logic [NUM_MASTER-1:0] w_winner;
    logic [PW-1:0]         w_winIdx;
    logic [PW-1:0]         w_ptrNext;
    logic                  w_load;

    // The current owner is masked so an acked master cannot win twice in a row.
    assign w_maskedReq = req_i & ~r_grant;
    assign w_load      = (|w_maskedReq) && ((r_state == ARB_IDLE) || ack_i);
    assign w_ptrNext   = (w_winIdx == PW'(NUM_MASTER - 1)) ? '0 : w_winIdx + PW'(1);

    always_comb begin
        w_promo = '0;
        for (int i = 0; i < NUM_MASTER; i++) begin
            w_promo[i] = (ARB_MODE == ARB_FIXED) && (STARVE_LIMIT != 0) &&
                         (r_starve[i] == CW'(STARVE_LIMIT));
        end
    end

    mem_arb_picker #(
        .NUM_MASTER (NUM_MASTER)
    ) u_picker (
        .i_req    (w_maskedReq),
        .i_ptr    (r_ptr),
        .i_promo  (w_promo),
        .i_mode   (ARB_MODE),
        .o_winner (w_winner),
        .o_idx    (w_winIdx)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= ARB_IDLE;
            r_grant <= '0;
            r_ptr   <= '0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (|w_maskedReq) begin
                        r_grant <= w_winner;
                        r_ptr   <= w_ptrNext;
                        r_state <= ARB_BUSY;
                    end
                end
                ARB_BUSY: begin
                    if (ack_i) begin
                        if (|w_maskedReq) begin
                            r_grant <= w_winner;
                            r_ptr   <= w_ptrNext;
                        end else begin
                            r_grant <= '0;
                            r_state <= ARB_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= ARB_IDLE;
                    r_grant <= '0;
                end
            endcase
        end
    end

    // A master only counts as losing when it actually competed in a grant load.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_MASTER; i++) begin
                r_starve[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_MASTER; i++) begin
                if (!req_i[i] || (w_load && w_winner[i])) begin
                    r_starve[i] <= '0;
                end else if (w_load && w_maskedReq[i] &&
                             (r_starve[i] != CW'(STARVE_LIMIT))) begin
                    r_starve[i] <= r_starve[i] + CW'(1);
                end
            end
        end
    end

    always_comb begin
        wdata_o = '0;
        waddr_o = '0;
        raddr_o = '0;
        wcyc_o  = 1'b0;
        rcyc_o  = 1'b0;
        for (int i = 0; i < NUM_MASTER; i++) begin
            if (r_grant[i]) begin
                wdata_o = wdata_o | wdata_i[i*LINE_W +: LINE_W];
                waddr_o = waddr_o | waddr_i[i*AW +: AW];
                raddr_o = raddr_o | raddr_i[i*AW +: AW];
                wcyc_o  = wcyc_o | wcyc_i[i];
                rcyc_o  = rcyc_o | rcyc_i[i];
            end
        end
    end

    assign ack_o   = r_grant & {NUM_MASTER{ack_i}};
    assign grant_o = r_grant;
    assign busy_o  = (r_state == ARB_BUSY);

endmodule

// File: tb/tb_main_mem_arb_n.sv
// Directed bench for main_mem_arb_n: one round-robin and one fixed-priority instance,
// with expected grant order queued when requests are driven.
module tb_main_mem_arb_n;
    import param_pkg::*;

    localparam int N  = 4;
    localparam int LW = BYTES_PER_LINE * 8;
    localparam int AB = MAIN_MEM_LINE_AW;

    logic            clk;
    logic            resetn;
    logic [N-1:0]    reqRr, reqFx;
    logic            ackRr, ackFx;
    logic [N*LW-1:0] wdata;
    logic [N*AB-1:0] waddr, raddr;
    logic [N-1:0]    wcyc, rcyc;

    logic [N-1:0]  ackORr, grantRr, ackOFx, grantFx;
    logic [LW-1:0] wdataORr, wdataOFx;
    logic [AB-1:0] waddrORr, raddrORr, waddrOFx, raddrOFx;
    logic          wcycORr, rcycORr, busyRr, wcycOFx, rcycOFx, busyFx;

    int checkCount = 0;
    int failCount  = 0;
    int sb[$];
    int e;

    logic [AB-1:0] waddrTab [N] = '{26'h10, 26'h11, 26'h1A, 26'h13};

    main_mem_arb_n #(.NUM_MASTER(N), .ARB_MODE(ARB_RR)) u_rr (
        .clk(clk), .resetn(resetn), .req_i(reqRr), .wdata_i(wdata),
        .waddr_i(waddr), .raddr_i(raddr), .wcyc_i(wcyc), .rcyc_i(rcyc),
        .ack_i(ackRr), .ack_o(ackORr), .wdata_o(wdataORr), .waddr_o(waddrORr),
        .raddr_o(raddrORr), .wcyc_o(wcycORr), .rcyc_o(rcycORr),
        .grant_o(grantRr), .busy_o(busyRr)
    );

    main_mem_arb_n #(.NUM_MASTER(N), .ARB_MODE(ARB_FIXED), .STARVE_LIMIT(2)) u_fx (
        .clk(clk), .resetn(resetn), .req_i(reqFx), .wdata_i(wdata),
        .waddr_i(waddr), .raddr_i(raddr), .wcyc_i(wcyc), .rcyc_i(rcyc),
        .ack_i(ackFx), .ack_o(ackOFx), .wdata_o(wdataOFx), .waddr_o(waddrOFx),
        .raddr_o(raddrOFx), .wcyc_o(wcycOFx), .rcyc_o(rcycOFx),
        .grant_o(grantFx), .busy_o(busyFx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [LW-1:0] lineOf(input int i);
        return {16{8'(8'hA0 + i)}};
    endfunction

    function automatic logic [N-1:0] oneHot(input int i);
        return N'(1) << i;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checkCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [N-1:0] rq, input logic ak);
        reqRr = rq;
        ackRr = ak;
    endtask

    task automatic popExp(output int v);
        checkOutput("sb_nonempty", 128'(sb.size() != 0), 128'(1));
        v = (sb.size() != 0) ? sb.pop_front() : 0;
    endtask

    initial begin
        resetn = 1'b0;
        reqFx  = '0;
        ackFx  = 1'b0;
        applyStimulus('0, 1'b0);
        for (int i = 0; i < N; i++) begin
            wdata[i*LW +: LW] = lineOf(i);
            waddr[i*AB +: AB] = waddrTab[i];
            raddr[i*AB +: AB] = AB'(26'h200 + i);
        end
        wcyc = 4'b0100;
        rcyc = 4'b1011;
        tick();
        tick();
        $display("[TB] reset state");
        checkOutput("rst_grant_rr", grantRr, 0);
        checkOutput("rst_busy_rr", busyRr, 0);
        checkOutput("rst_waddr_rr", waddrORr, 0);
        checkOutput("rst_grant_fx", grantFx, 0);
        checkOutput("rst_busy_fx", busyFx, 0);
        resetn = 1'b1;

        $display("[TB] idle with no requests");
        for (int c = 0; c < 5; c++) begin
            tick();
            checkOutput("idle_grant", grantRr, 0);
            checkOutput("idle_busy", busyRr, 0);
            checkOutput("idle_wdata", wdataORr, 0);
            checkOutput("idle_wcyc", wcycORr, 0);
        end

        $display("[TB] round robin, all masters requesting");
        applyStimulus(4'b1111, 1'b0);
        sb.push_back(0); sb.push_back(1); sb.push_back(2); sb.push_back(3); sb.push_back(0);
        tick();
        for (int k = 0; k < 5; k++) begin
            ackRr = 1'b0;
            popExp(e);
            checkOutput("rr_grant", grantRr, oneHot(e));
            checkOutput("rr_busy", busyRr, 1);
            checkOutput("rr_waddr", waddrORr, waddrTab[e]);
            tick();
            tick();
            ackRr = 1'b1;
            if (k == 4) reqRr = '0;
            #1;
            checkOutput("rr_ack", ackORr, oneHot(e));
            tick();
        end
        ackRr = 1'b0;
        checkOutput("rr_end_busy", busyRr, 0);
        checkOutput("rr_end_grant", grantRr, 0);

        $display("[TB] fixed priority with starvation promotion");
        reqFx = 4'b1011;
        sb.push_back(0); sb.push_back(1); sb.push_back(3); sb.push_back(0); sb.push_back(1);
        tick();
        for (int k = 0; k < 5; k++) begin
            ackFx = 1'b0;
            popExp(e);
            checkOutput("fx_grant", grantFx, oneHot(e));
            checkOutput("fx_busy", busyFx, 1);
            tick();
            ackFx = 1'b1;
            if (k == 4) reqFx = '0;
            #1;
            checkOutput("fx_ack", ackOFx, oneHot(e));
            tick();
        end
        ackFx = 1'b0;
        checkOutput("fx_end_busy", busyFx, 0);

        $display("[TB] master 2 write routing");
        applyStimulus(4'b0100, 1'b0);
        sb.push_back(2);
        tick();
        popExp(e);
        checkOutput("m2_grant", grantRr, oneHot(e));
        checkOutput("m2_waddr", waddrORr, 26'h1A);
        checkOutput("m2_raddr", raddrORr, 26'h202);
        checkOutput("m2_wdata", wdataORr, lineOf(2));
        checkOutput("m2_wcyc", wcycORr, 1);
        checkOutput("m2_rcyc", rcycORr, 0);
        applyStimulus(4'b0000, 1'b1);
        #1;
        checkOutput("m2_ack", ackORr, 4'b0100);
        tick();
        applyStimulus(4'b0000, 1'b0);
        checkOutput("m2_idle", busyRr, 0);

        $display("[TB] single requester re-grant after ack");
        applyStimulus(4'b0010, 1'b0);
        sb.push_back(1);
        tick();
        popExp(e);
        checkOutput("m1_grant", grantRr, oneHot(e));
        ackRr = 1'b1;
        tick();
        ackRr = 1'b0;
        checkOutput("m1_masked_busy", busyRr, 0);
        checkOutput("m1_masked_grant", grantRr, 0);
        sb.push_back(1);
        tick();
        popExp(e);
        checkOutput("m1_regrant", grantRr, oneHot(e));
        checkOutput("m1_regrant_busy", busyRr, 1);

        $display("[TB] reset during a transaction");
        resetn = 1'b0;
        tick();
        checkOutput("rstmid_grant", grantRr, 0);
        checkOutput("rstmid_busy", busyRr, 0);
        resetn = 1'b1;
        applyStimulus(4'b0000, 1'b1);
        #1;
        checkOutput("stray_ack", ackORr, 0);
        tick();
        ackRr = 1'b0;
        checkOutput("stray_busy", busyRr, 0);
        checkOutput("stray_grant", grantRr, 0);

        checkOutput("sb_empty", 128'(sb.size()), 0);
        $display("%0d/%0d checks passed", checkCount - failCount, checkCount);
        $finish;
    end

endmodule

// File: doc/main_mem_arb_n.md
# main_mem_arb_n

Parametrised N-master arbiter between the per-core cache controllers and the single main-memory line port. It supports fixed-priority mode with starvation promotion, or round-robin mode. A granted master owns the memory port until main memory returns `ack_i`. Arbitration for the next transaction happens in the ack cycle, so back-to-back transactions have no bubble. It replaces the 2-master fixed-priority arbiter in the interconnect.

## Interface
- `NUM_MASTER`, default 4: number of requesters, must be ≥ 2.
- `LINE_W`, default `BYTES_PER_LINE*8`: line data width.
- `AW`, default `MAIN_MEM_LINE_AW`: line address width.
- `ARB_MODE`, default `ARB_RR`: selects `ARB_FIXED` (master 0 highest) or `ARB_RR`.
- `STARVE_LIMIT`, default 8: number of lost arbitrations before a master is promoted (`ARB_FIXED` only); 0 disables promotion.
- `clk`  in  1  clock; one clock domain.
- `resetn`  in  1  synchronous, active-low reset.
- `req_i`  in  `NUM_MASTER`  request; held by the master until its ack.
- `wdata_i`  in  `NUM_MASTER` × `LINE_W`  write line.
- `waddr_i`  in  `NUM_MASTER` × `AW`  write line address.
- `raddr_i`  in  `NUM_MASTER` × `AW`  read line address.
- `wcyc_i`  in  `NUM_MASTER`  write cycle.
- `rcyc_i`  in  `NUM_MASTER`  read cycle.
- `ack_i`  in  1  main memory completion, single-cycle pulse.
- `ack_o`  out  `NUM_MASTER`  `ack_i` routed to the granted master.
- `wdata_o`  out  `LINE_W`  muxed write data to memory.
- `waddr_o`  out  `AW`  muxed write address to memory.
- `raddr_o`  out  `AW`  muxed read address to memory.
- `wcyc_o`  out  1  muxed write cycle to memory.
- `rcyc_o`  out  1  muxed read cycle to memory.
- `grant_o`  out  `NUM_MASTER`  registered one-hot grant.
- `busy_o`  out  1  a transaction is outstanding.

## Operation
- State machine `IDLE` / `BUSY`, with a registered one-hot grant `g_r`.
- `IDLE`:
  - If `|req_i`, the picker selects a winner, `g_r` loads its one-hot value and the state goes to `BUSY` next cycle.
  - Otherwise the block stays in `IDLE`.
- `BUSY`:
  - All `*_o` memory signals are driven from the master selected by `g_r`.
  - `ack_o[g] = ack_i`; every other `ack_o` bit is 0.
- On `ack_i` in `BUSY`:
  - Re-arbitrate in the same cycle using `req_i & ~g_r` (the acked master is masked for that cycle only).
  - If that masked request vector is non-zero, load the new grant and stay in `BUSY`.
  - Otherwise clear `g_r` and go to `IDLE`.
- `ack_i` in `IDLE` is ignored: no `ack_o` bit is set and no state changes.
- If `req_i[g]` drops before ack (a protocol violation), the grant is held until `ack_i` anyway.
- `ARB_RR` mode:
  - Pointer `ptr` is `$clog2(NUM_MASTER)` bits.
  - Search starts at `ptr`, goes upward and wraps from `NUM_MASTER-1` to 0.
  - On every grant, `ptr` ← winner + 1, modulo `NUM_MASTER`.
- `ARB_FIXED` mode:
  - Lowest index wins, except that a promoted master wins first.
  - Among several promoted masters, the lowest index wins.
- Starvation counter per master (`$clog2(STARVE_LIMIT+1)` bits, saturating):
  - It increments in each grant-load cycle where the master requests but loses.
  - It clears when the master is granted or stops requesting.
  - A master is promoted when its count equals `STARVE_LIMIT`.

## Timing
- Reset values: `g_r`=0, state `IDLE`, `ptr`=0, starvation counters=0.
- Outputs after reset: all `*_o`=0, `grant_o`=0, `busy_o`=0.
- Reset asserted mid-transaction drops the grant immediately on that edge. No ack is forwarded afterwards.
- Grant latency: request at cycle t (from `IDLE`) → `grant_o` and muxed outputs valid at t+1.
- `ack_o` is combinational from `ack_i` (same cycle).
- Back-to-back: ack at cycle t → next master's outputs at t+1 with no idle cycle.
- In `IDLE` all muxed outputs are 0.

## Structure
- `param_pkg` gets `typedef enum logic {ARB_FIXED, ARB_RR} arb_mode_e`.
- `BYTES_PER_LINE` and `MAIN_MEM_LINE_AW` stay in `param_pkg`.
- One combinational sub-module, `mem_arb_picker`:
  - Inputs: masked request vector, `ptr`, promoted mask, mode.
  - Output: one-hot winner plus index.
- The top level holds the FSM, `ptr`, the starvation counters and the output mux.

## Test plan
- Reset, then `req_i`=4'b0000 for 5 cycles → all outputs 0, `busy_o`=0.
- `ARB_RR`, `req_i`=4'b1111 held, `ack_i` every 3rd cycle → grants in order 0,1,2,3,0; `ack_o` one-hot follows the grant; no idle cycle between transactions.
- `ARB_FIXED`, `STARVE_LIMIT`=2, masters 0 and 1 constantly re-requesting, master 3 requesting:
  - Master 3 loses 2 arbitrations, then is granted at the third.
  - Master 3's counter clears on its grant.
- Master 2 granted with `waddr_i[2]`=0x1A, `wcyc_i[2]`=1 → at t+1 `waddr_o`=0x1A, `wcyc_o`=1, `grant_o`=4'b0100. With `ack_i`=1: `ack_o`=4'b0100.
- `resetn`=0 while `busy_o`=1 → next cycle `grant_o`=0, `busy_o`=0. A stray `ack_i` afterwards produces `ack_o`=0.
- Single requester, master 1: ack at t → `IDLE` at t+1 (acked master masked). Its request held at t+1 → granted again at t+2.
